if_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, directly upstream of the decode stage. It owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and buffers returned instructions in a small FIFO. The FIFO head is presented to decode as instruction, PC and valid. Decode back-pressure (`stall_in`) and control-flow redirects (`redirect_en_in`) are handled here.

---
 rtl/if_fetch.sv | 212 +++++++++++++++++++++
 tb/tb_if_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- MIPS instruction-fetch stage
//
// Owns the program counter and fetches one word at a time from instruction
// memory over a req/ack handshake. There is never more than one request
// outstanding. Returned words are buffered in a small shift-register FIFO
// whose head is registered and presented to decode.
//
// Configuration macro:
//   IF_FIFO2_EN  defined   -> FIFO depth 2 (one instruction per cycle)
//                undefined -> FIFO depth 1 (one instruction per two cycles)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_out      fetch request, held until acknowledged
//   imem_addr_out     word-aligned fetch address, held until acknowledged
//   imem_ack_in       memory accepts address; imem_data_in valid same cycle
//   imem_data_in      fetched instruction word
//   redirect_en_in    one-cycle pulse: flush and restart at redirect_pc_in
//   redirect_pc_in    redirect target (low two bits ignored)
//   stall_in          decode not accepting this cycle
//   inst_valid_out    FIFO head valid
//   inst_data_out     head instruction (0 when not valid)
//   inst_pc_out       PC of head instruction (0 when not valid)
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    INST_DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req_out,
    output logic [ADDR_WIDTH-1:0]      imem_addr_out,
    input  logic                       imem_ack_in,
    input  logic [INST_DATA_WIDTH-1:0] imem_data_in,
    input  logic                       redirect_en_in,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc_in,
    input  logic                       stall_in,
    output logic                       inst_valid_out,
    output logic [INST_DATA_WIDTH-1:0] inst_data_out,
    output logic [ADDR_WIDTH-1:0]      inst_pc_out
);

`ifdef IF_FIFO2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [1:0]            DEPTH_CNT  = 2'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                     state_r, state_s;
    logic [ADDR_WIDTH-1:0]      pc_r, pc_s;
    logic [ADDR_WIDTH-1:0]      addr_r, addr_s;
    logic                       req_r, req_s;
    logic [1:0]                 count_r, count_s;
    logic                       valid_r, valid_s;
    logic                       push_s, pop_s;
    logic [1:0]                 wr_idx_s;

    // Entries at index >= count are kept at zero so the head reads as NOP.
    logic [ADDR_WIDTH-1:0]      fifo_pc_r   [DEPTH];
    logic [INST_DATA_WIDTH-1:0] fifo_data_r [DEPTH];
    logic [ADDR_WIDTH-1:0]      fifo_pc_s   [DEPTH];
    logic [INST_DATA_WIDTH-1:0] fifo_data_s [DEPTH];
    logic [ADDR_WIDTH-1:0]      ext_pc_s    [DEPTH+1];
    logic [INST_DATA_WIDTH-1:0] ext_data_s  [DEPTH+1];

    // FIFO next state: redirect flushes, otherwise shift on pop then write on push.
    always_comb begin
        pop_s    = valid_r && !stall_in;
        push_s   = (state_r == S_FETCH) && imem_ack_in && !redirect_en_in;
        wr_idx_s = count_r - {1'b0, pop_s};
        for (int i = 0; i < DEPTH; i++) begin
            ext_pc_s[i]   = fifo_pc_r[i];
            ext_data_s[i] = fifo_data_r[i];
        end
        ext_pc_s[DEPTH]   = '0;
        ext_data_s[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (redirect_en_in) begin
                fifo_pc_s[i]   = '0;
                fifo_data_s[i] = '0;
            end else begin
                if (pop_s) begin
                    fifo_pc_s[i]   = ext_pc_s[i+1];
                    fifo_data_s[i] = ext_data_s[i+1];
                end else begin
                    fifo_pc_s[i]   = ext_pc_s[i];
                    fifo_data_s[i] = ext_data_s[i];
                end
                if (push_s && (wr_idx_s == 2'(i))) begin
                    fifo_pc_s[i]   = pc_r;
                    fifo_data_s[i] = imem_data_in;
                end else begin
                    fifo_pc_s[i]   = fifo_pc_s[i];
                    fifo_data_s[i] = fifo_data_s[i];
                end
            end
        end
        if (redirect_en_in) begin
            count_s = 2'd0;
        end else begin
            count_s = count_r - {1'b0, pop_s} + {1'b0, push_s};
        end
        valid_s = (count_s != 2'd0);
    end

    // Fetch FSM next state, PC and registered request/address values.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        if (redirect_en_in) begin
            pc_s = redirect_pc_in & ALIGN_MASK;
        end else if (push_s) begin
            pc_s = pc_r + PC_STEP;
        end else begin
            pc_s = pc_r;
        end
        case (state_r)
            S_IDLE: begin
                state_s = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_en_in) begin
                    // An unacknowledged request must still be completed.
                    state_s = imem_ack_in ? S_FETCH : S_DRAIN;
                end else if (count_s == DEPTH_CNT) begin
                    state_s = S_FULL;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_FULL: begin
                if (redirect_en_in || pop_s) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_FULL;
                end
            end
            S_DRAIN: begin
                if (imem_ack_in) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        req_s = (state_s == S_FETCH) || (state_s == S_DRAIN);
        // While draining, the abandoned address is held; pc already has the target.
        if (state_s == S_DRAIN) begin
            addr_s = addr_r;
        end else begin
            addr_s = pc_s;
        end
    end

    // FSM, PC and memory-interface registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_ADDR;
            addr_r  <= RESET_ADDR;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            addr_r  <= addr_s;
            req_r   <= req_s;
        end
    end

    // FIFO storage, occupancy and registered head-valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= '0;
                fifo_data_r[i] <= '0;
            end
        end else begin
            count_r <= count_s;
            valid_r <= valid_s;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= fifo_pc_s[i];
                fifo_data_r[i] <= fifo_data_s[i];
            end
        end
    end

    assign imem_req_out   = req_r;
    assign imem_addr_out  = addr_r;
    assign inst_valid_out = valid_r;
    assign inst_data_out  = fifo_data_r[0];
    assign inst_pc_out    = fifo_pc_r[0];

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch
//
// A memory model returns addr>>2 after a programmable wait. A scoreboard
// queue receives {pc, data} on every acknowledged, non-abandoned fetch and is
// popped when decode accepts the head. Works for both FIFO depths
// (IF_FIFO2_EN defined or not).
// -----------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
`ifdef IF_FIFO2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;
    logic        redirect_en_in;
    logic [31:0] redirect_pc_in;
    logic        stall_in;
    logic        inst_valid_out;
    logic [31:0] inst_data_out;
    logic [31:0] inst_pc_out;

    int lat;
    int wait_cnt;
    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];
    logic [31:0] exp_pc;
    logic [31:0] drain_addr;
    bit          drain_pending;

    if_fetch #(
        .ADDR_WIDTH      (32),
        .INST_DATA_WIDTH (32),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_out   (imem_req_out),
        .imem_addr_out  (imem_addr_out),
        .imem_ack_in    (imem_ack_in),
        .imem_data_in   (imem_data_in),
        .redirect_en_in (redirect_en_in),
        .redirect_pc_in (redirect_pc_in),
        .stall_in       (stall_in),
        .inst_valid_out (inst_valid_out),
        .inst_data_out  (inst_data_out),
        .inst_pc_out    (inst_pc_out)
    );

    always #5 clk = ~clk;

    // Memory model: acknowledge once the request has waited lat cycles.
    assign imem_ack_in  = imem_req_out && (wait_cnt >= lat);
    assign imem_data_in = {2'b00, imem_addr_out[31:2]};

    // Memory model wait counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (imem_req_out && !imem_ack_in) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req",   {63'd0, imem_req_out},   64'd0);
        check_eq("rst_addr",  {32'd0, imem_addr_out},  {32'd0, RST_PC});
        check_eq("rst_valid", {63'd0, inst_valid_out}, 64'd0);
        check_eq("rst_data",  {32'd0, inst_data_out},  64'd0);
        check_eq("rst_pc",    {32'd0, inst_pc_out},    64'd0);
    endtask

    // Scoreboard monitor: compare at the falling edge, then apply this cycle's events.
    initial begin
        bit live;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                exp_pc        = RST_PC;
                drain_pending = 1'b0;
                drain_addr    = 32'd0;
            end else begin
                check_eq("inst_valid", {63'd0, inst_valid_out}, {63'd0, sb_q.size() != 0});
                if (sb_q.size() != 0) begin
                    check_eq("inst_pc",   {32'd0, inst_pc_out},   {32'd0, sb_q[0][63:32]});
                    check_eq("inst_data", {32'd0, inst_data_out}, {32'd0, sb_q[0][31:0]});
                end else begin
                    check_eq("nop_pc",   {32'd0, inst_pc_out},   64'd0);
                    check_eq("nop_data", {32'd0, inst_data_out}, 64'd0);
                end
                if (imem_req_out) begin
                    if (drain_pending) begin
                        check_eq("drain_addr", {32'd0, imem_addr_out}, {32'd0, drain_addr});
                    end else begin
                        check_eq("fetch_addr", {32'd0, imem_addr_out}, {32'd0, exp_pc});
                    end
                end
                live = imem_ack_in && !drain_pending && !redirect_en_in;
                if (imem_ack_in) drain_pending = 1'b0;
                if (redirect_en_in) begin
                    sb_q.delete();
                    exp_pc = redirect_pc_in & 32'hFFFF_FFFC;
                    if (imem_req_out && !imem_ack_in) begin
                        drain_pending = 1'b1;
                        drain_addr    = imem_addr_out;
                    end
                end else begin
                    if (inst_valid_out && !stall_in && sb_q.size() != 0) void'(sb_q.pop_front());
                    if (live) begin
                        sb_q.push_back({exp_pc, 2'b00, exp_pc[31:2]});
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int  nreq;
        int  nvalid;
        bit  found;

        rst_n          = 1'b0;
        stall_in       = 1'b0;
        redirect_en_in = 1'b0;
        redirect_pc_in = 32'd0;
        lat            = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 rst_n = 1'b1;

        // First fetch at RESET_PC, next one wraps to zero.
        @(posedge clk); #1;
        check_eq("first_req",  {63'd0, imem_req_out}, 64'd1);
        check_eq("first_addr", {32'd0, imem_addr_out}, {32'd0, RST_PC});
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(posedge clk); #1;
            if (imem_req_out) found = 1'b1;
        end
        check_eq("wrap_req_seen", {63'd0, found}, 64'd1);
        check_eq("wrap_addr", {32'd0, imem_addr_out}, 64'd0);

        // Free-running throughput with zero-wait memory.
        repeat (6) @(negedge clk);
        nreq   = 0;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req_out)   nreq++;
            if (inst_valid_out) nvalid++;
        end
        check_eq("req_rate",   64'(nreq),   64'(DEPTH == 2 ? 8 : 4));
        check_eq("valid_rate", 64'(nvalid), 64'(DEPTH == 2 ? 8 : 4));

        // Stall fill: request drops once the FIFO is full.
        @(posedge clk); #1 stall_in = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("stall_req_drop", {63'd0, imem_req_out},   64'd0);
        check_eq("stall_valid",    {63'd0, inst_valid_out}, 64'd1);
        @(posedge clk); #1 stall_in = 1'b0;
        repeat (10) @(posedge clk);

        // Redirect while a slow request is outstanding.
        #1 lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (imem_req_out && !imem_ack_in) found = 1'b1;
        end
        check_eq("pending_found", {63'd0, found}, 64'd1);
        redirect_en_in = 1'b1;
        redirect_pc_in = 32'h0000_1003;
        @(posedge clk); #1 redirect_en_in = 1'b0;
        check_eq("drain_req_held", {63'd0, imem_req_out}, 64'd1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (imem_req_out && imem_addr_out == 32'h0000_1000) found = 1'b1;
        end
        check_eq("redirect_target_req", {63'd0, found}, 64'd1);
        repeat (20) @(posedge clk);

        // Redirect while stalled with a full FIFO.
        #1 lat = 0;
        stall_in = 1'b1;
        repeat (6) @(posedge clk);
        #1 redirect_en_in = 1'b1;
        redirect_pc_in = 32'h0000_0200;
        @(posedge clk); #1 redirect_en_in = 1'b0;
        check_eq("redir_valid_drop", {63'd0, inst_valid_out}, 64'd0);
        repeat (3) @(posedge clk);
        #1 check_eq("redir_head_pc", {32'd0, inst_pc_out}, 64'h200);
        stall_in = 1'b0;
        repeat (10) @(posedge clk);

        // Reset in the middle of an outstanding request.
        #1 lat = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (imem_req_out && !imem_ack_in) found = 1'b1;
        end
        check_eq("mid_pending_found", {63'd0, found}, 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk); #1 rst_n = 1'b1;
        lat = 0;
        repeat (12) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
